// File: rtl/regfile_scoreboard_if.sv
// Decode / write-back bus for the register file with pending-write scoreboard.
// The master side is the pipeline (decode + write-back); the slave side is the
// register file.
interface regfile_scoreboard_if #(
    parameter int WIDTH  = 16,
    parameter int NREG_W = 3
);
    logic [NREG_W-1:0] read1RegSel;
    logic [NREG_W-1:0] read2RegSel;
    logic              read1En;
    logic              read2En;
    logic [WIDTH-1:0]  read1Data;
    logic [WIDTH-1:0]  read2Data;
    logic              writeEn;
    logic [NREG_W-1:0] writeRegSel;
    logic [WIDTH-1:0]  writeData;
    logic              issueEn;
    logic [NREG_W-1:0] issueRegSel;
    logic              stall;
    logic              err;

    modport master (
        output read1RegSel, read2RegSel, read1En, read2En,
        output writeEn, writeRegSel, writeData,
        output issueEn, issueRegSel,
        input  read1Data, read2Data, stall, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, read1En, read2En,
        input  writeEn, writeRegSel, writeData,
        input  issueEn, issueRegSel,
        output read1Data, read2Data, stall, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file (8 x 16 bit by default) with write-to-read
// bypass and a 2-bit pending-write counter per register. Decode reads the
// combinational stall; err is a sticky over/underflow flag of the counters.
module regfile_scoreboard #(
    parameter int WIDTH  = 16,
    parameter int NREG_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int NREG = 1 << NREG_W;

    // While reset is asserted a write is discarded, so it must not bypass either.
    logic              wr_act;
    logic [WIDTH-1:0]  data_q [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   fault;
    logic              err_reg;

    assign wr_act = bus.writeEn & rst;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [WIDTH-1:0] data_reg;
            logic [1:0]       pend_reg;
            logic [1:0]       pend_next;
            logic             wr_hit;
            logic             is_hit;

            assign wr_hit = wr_act && (bus.writeRegSel == NREG_W'(gi));
            assign is_hit = bus.issueEn && (bus.issueRegSel == NREG_W'(gi));

            // Saturating pending count; a same-cycle issue and write cancel out.
            always_comb begin
                pend_next = pend_reg;
                if (is_hit && !wr_hit && pend_reg != 2'd3)
                    pend_next = pend_reg + 2'd1;
                else if (wr_hit && !is_hit && pend_reg != 2'd0)
                    pend_next = pend_reg - 2'd1;
            end

            assign fault[gi] = (is_hit && !wr_hit && pend_reg == 2'd3) ||
                               (wr_hit && !is_hit && pend_reg == 2'd0);

            // Outstanding writes still owed after this cycle's write-back; an
            // underflowing write (count already 0) leaves nothing outstanding.
            assign busy[gi] = wr_hit ? (pend_reg > 2'd1) : (pend_reg != 2'd0);

            assign data_q[gi] = data_reg;

            // Register contents and pending counter.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                    pend_reg <= 2'd0;
                end else begin
                    if (wr_hit)
                        data_reg <= bus.writeData;
                    pend_reg <= pend_next;
                end
            end
        end
    endgenerate

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_reg <= 1'b0;
        else if (|fault)
            err_reg <= 1'b1;
    end

    assign bus.read1Data = (wr_act && bus.writeRegSel == bus.read1RegSel)
                           ? bus.writeData : data_q[bus.read1RegSel];
    assign bus.read2Data = (wr_act && bus.writeRegSel == bus.read2RegSel)
                           ? bus.writeData : data_q[bus.read2RegSel];

    assign bus.stall = (bus.read1En && busy[bus.read1RegSel]) ||
                       (bus.read2En && busy[bus.read2RegSel]);
    assign bus.err   = err_reg;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. The stimulus process drives one
// vector per cycle and queues its hand-computed expected outputs; a monitor
// on the falling edge pops and compares whenever a vector is marked for check.
module tb_regfile_scoreboard;
    logic clk;
    logic rst;
    logic chk_req;
    int   checks;
    int   errors;

    typedef struct {
        string       name;
        logic [15:0] r1;
        logic [15:0] r2;
        logic        st;
        logic        er;
    } exp_t;

    exp_t exp_q[$];

    regfile_scoreboard_if #(.WIDTH(16), .NREG_W(3)) bus ();

    regfile_scoreboard #(.WIDTH(16), .NREG_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Drive one vector, queue its expectation, advance one clock.
    task automatic step(input string nm,
                        input logic we, input logic [2:0] ws, input logic [15:0] wd,
                        input logic ie, input logic [2:0] is,
                        input logic [2:0] r1s, input logic r1e,
                        input logic [2:0] r2s, input logic r2e,
                        input logic [15:0] e1, input logic [15:0] e2,
                        input logic est, input logic eer);
        exp_t e;
        bus.writeEn     = we;
        bus.writeRegSel = ws;
        bus.writeData   = wd;
        bus.issueEn     = ie;
        bus.issueRegSel = is;
        bus.read1RegSel = r1s;
        bus.read1En     = r1e;
        bus.read2RegSel = r2s;
        bus.read2En     = r2e;
        e.name = nm; e.r1 = e1; e.r2 = e2; e.st = est; e.er = eer;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_empty: got no expectation, required one");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("%s: read1Data=%h read2Data=%h stall=%b err=%b",
                         e.name, bus.read1Data, bus.read2Data, bus.stall, bus.err);
                checks += 4;
                if (bus.read1Data !== e.r1) begin
                    errors++;
                    $display("FAIL %s.read1Data: got %h required %h", e.name, bus.read1Data, e.r1);
                end
                if (bus.read2Data !== e.r2) begin
                    errors++;
                    $display("FAIL %s.read2Data: got %h required %h", e.name, bus.read2Data, e.r2);
                end
                if (bus.stall !== e.st) begin
                    errors++;
                    $display("FAIL %s.stall: got %b required %b", e.name, bus.stall, e.st);
                end
                if (bus.err !== e.er) begin
                    errors++;
                    $display("FAIL %s.err: got %b required %b", e.name, bus.err, e.er);
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        chk_req = 1'b0;
        rst     = 1'b0;

        // Reset held with a write and issue pending: everything reads zero.
        step("reset_hold", 1, 3'd3, 16'hAAAA, 1, 3'd3, 3'd3, 1, 3'd5, 1, 16'h0000, 16'h0000, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step($sformatf("reset_read_r%0d_r%0d", 2*k, 2*k+1), 0, 3'd0, 16'h0, 0, 3'd0,
                 3'(2*k), 1, 3'(2*k+1), 1, 16'h0000, 16'h0000, 0, 0);
        end

        // Write with bypass (r3 issued first so the write is not an underflow).
        step("issue_r3_no_self_stall", 0, 3'd0, 16'h0, 1, 3'd3, 3'd3, 1, 3'd4, 0, 16'h0000, 16'h0000, 0, 0);
        step("write_r3_bypass", 1, 3'd3, 16'hBEEF, 0, 3'd0, 3'd3, 1, 3'd4, 0, 16'hBEEF, 16'h0000, 0, 0);
        step("read_r3_stored", 0, 3'd0, 16'h0, 0, 3'd0, 3'd3, 1, 3'd4, 0, 16'hBEEF, 16'h0000, 0, 0);

        // RAW stall on r5 through read port 2.
        step("raw_issue_r5", 0, 3'd0, 16'h0, 1, 3'd5, 3'd3, 0, 3'd5, 1, 16'hBEEF, 16'h0000, 0, 0);
        step("raw_c1_stall", 0, 3'd0, 16'h0, 0, 3'd0, 3'd3, 0, 3'd5, 1, 16'hBEEF, 16'h0000, 1, 0);
        step("raw_c2_stall", 0, 3'd0, 16'h0, 0, 3'd0, 3'd3, 0, 3'd5, 1, 16'hBEEF, 16'h0000, 1, 0);
        step("raw_c3_write", 1, 3'd5, 16'h1234, 0, 3'd0, 3'd3, 0, 3'd5, 1, 16'hBEEF, 16'h1234, 0, 0);

        // Three in-flight writes to r2, then an overflowing fourth issue.
        step("multi_issue1", 0, 3'd0, 16'h0, 1, 3'd2, 3'd2, 1, 3'd5, 0, 16'h0000, 16'h1234, 0, 0);
        step("multi_issue2", 0, 3'd0, 16'h0, 1, 3'd2, 3'd2, 1, 3'd5, 0, 16'h0000, 16'h1234, 1, 0);
        step("multi_issue3", 0, 3'd0, 16'h0, 1, 3'd2, 3'd2, 1, 3'd5, 0, 16'h0000, 16'h1234, 1, 0);
        step("overflow_issue4", 0, 3'd0, 16'h0, 1, 3'd2, 3'd2, 1, 3'd5, 0, 16'h0000, 16'h1234, 1, 0);
        step("multi_write1", 1, 3'd2, 16'h0011, 0, 3'd0, 3'd2, 1, 3'd5, 0, 16'h0011, 16'h1234, 1, 1);
        step("multi_write2", 1, 3'd2, 16'h0022, 0, 3'd0, 3'd2, 1, 3'd5, 0, 16'h0022, 16'h1234, 1, 1);
        step("multi_write3", 1, 3'd2, 16'h0033, 0, 3'd0, 3'd2, 1, 3'd5, 0, 16'h0033, 16'h1234, 0, 1);
        step("err_sticky", 0, 3'd0, 16'h0, 0, 3'd0, 3'd2, 1, 3'd5, 0, 16'h0033, 16'h1234, 0, 1);

        // Simultaneous issue and write on r1 with one write outstanding.
        step("sim_issue_r1", 0, 3'd0, 16'h0, 1, 3'd1, 3'd1, 1, 3'd5, 0, 16'h0000, 16'h1234, 0, 1);
        step("sim_issue_write_r1", 1, 3'd1, 16'h5555, 1, 3'd1, 3'd1, 1, 3'd5, 0, 16'h5555, 16'h1234, 0, 1);
        step("sim_after_same_sel", 0, 3'd0, 16'h0, 0, 3'd0, 3'd1, 1, 3'd1, 1, 16'h5555, 16'h5555, 1, 1);

        // Asynchronous reset between edges clears data, counters and err.
        rst = 1'b0;
        step("async_reset", 0, 3'd0, 16'h0, 0, 3'd0, 3'd1, 1, 3'd1, 1, 16'h0000, 16'h0000, 0, 0);
        rst = 1'b1;
        step("after_reset", 0, 3'd0, 16'h0, 0, 3'd0, 3'd1, 1, 3'd2, 1, 16'h0000, 16'h0000, 0, 0);

        // Underflow: write r7 with nothing pending still stores the data.
        step("underflow_write_r7", 1, 3'd7, 16'h7777, 0, 3'd0, 3'd7, 1, 3'd6, 1, 16'h7777, 16'h0000, 0, 0);
        step("underflow_err", 0, 3'd0, 16'h0, 0, 3'd0, 3'd7, 1, 3'd6, 1, 16'h7777, 16'h0000, 0, 1);

        // Issue r4 while writing r6: independent updates.
        step("issue_r4_write_r6", 1, 3'd6, 16'h6666, 1, 3'd4, 3'd6, 1, 3'd4, 1, 16'h6666, 16'h0000, 0, 1);
        step("indep_r4_stall", 0, 3'd0, 16'h0, 0, 3'd0, 3'd6, 1, 3'd4, 1, 16'h6666, 16'h0000, 1, 1);

        // Bounded drain: every queued expectation must have been consumed.
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
